decode_pipe_stage: RTL and testbench
====================================

# decode_pipe_stage

Parametrised decode stage with an integrated ID/EX pipeline register, a bypassing register file, and load-use hazard detection. It takes a fetched instruction and PC and decodes control through the shared control decoder. It reads operands, with same-cycle writeback forwarding, and builds the extended immediate. It registers everything into a valid-tagged ID/EX bundle, and it stalls fetch and inserts a bubble when the instruction in EX is a load feeding the instruction in ID. The block sits between fetch and execute and replaces the purely combinational decode path.

## Interface
- `N`, 32: datapath width, must be ≥ 32.
- `REG_AW`, 4: register address width. The register file holds `2**REG_AW` entries; the top address is the PC alias.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `inst`/`pc` carry a real instruction.
- `inst` in N: instruction.
  - opcode [31:22], A1 [21:18] (alt [17:14]), Rd [17:14], A2 [13:10] (alt [17:14]).
  - imm14 [13:0], imm27 [26:0].
- `pc` in N: PC of `inst`, returned on reads of the PC alias.
- `stall_in` in 1: downstream not ready; hold ID/EX.
- `flush` in 1: kill the instruction entering ID/EX (branch taken).
- `wb_we` in 1: writeback enable.
- `wb_addr` in REG_AW: writeback register.
- `wb_data` in N: writeback value.
- `out_valid` out 1: ID/EX bundle valid.
- `ra` out N: operand A.
- `rb` out N: operand B.
- `ext_imm` out N: extended immediate.
- `rd_out` out REG_AW: destination register.
- `ra_addr` out REG_AW: source address A, for EX forwarding.
- `rb_addr` out REG_AW: source address B, for EX forwarding.
- `ctrl_out` out `$bits(ctrl_t)`: registered control bundle.
- `stall_req` out 1: combinational; fetch must hold `inst`/`pc` this cycle.

## Operation
- **Address selection** (ctrl fields `rn_src`, `rs_src`): A1 = `rn_src` ? [17:14] : [21:18]; A2 = `rs_src` ? [17:14] : [13:10].
- **Immediate:**
  - `imm_src`=1 uses imm27; otherwise imm14 zero-padded to 27 bits.
  - `imm_ext`=1 sign-extends from the selected field's MSB; 0 zero-extends to N.
- **Register file:**
  - Write on `clk` when `wb_we`.
  - Writes to the PC alias (all-ones address) are ignored.
  - Reads of the PC alias return `pc`.
- **Bypass:** if `wb_we` && `wb_addr`==A1 (or A2) && the address is not the PC alias, the read returns `wb_data` (write-before-read).
- **Hazard:** `hazard` = `in_valid` && `out_valid` && `ctrl_out.is_load` && `rd_out` != PC alias && ((`a1_used` && A1==`rd_out`) || (`a2_used` && A2==`rd_out`)).
- **`stall_req`** = `hazard` || `stall_in`.
- **ID/EX update priority, per cycle:**
  1. `rst`: all outputs 0, `ctrl_out` = `CTRL_NOP`, register file cleared to 0.
  2. `flush`: `out_valid`←0, `ctrl_out`←`CTRL_NOP`; data fields don't-care, but driven 0.
  3. `stall_in`: hold all ID/EX contents unchanged.
  4. `hazard`: bubble; `out_valid`←0, `ctrl_out`←`CTRL_NOP`.
  5. Otherwise: load the decoded bundle; `out_valid`←`in_valid`. If `in_valid`=0, `ctrl_out`←`CTRL_NOP`.
- `flush` overrides `stall_in`: a killed bubble is not held.
- `stall_req` is still asserted from `hazard`/`stall_in` during `flush`, but fetch is redirected, so that is harmless.

## Timing
- Decode-to-output latency: 1 cycle. The bundle for `inst` sampled at edge k appears after edge k.
- A load-use pair costs exactly 1 bubble:
  - Cycle k: hazard seen, bubble loaded.
  - Cycle k+1: the consumer is re-presented by fetch (held) and loads; the load is now in MEM and is forwarded downstream.
- A writeback in the same cycle as the read is visible in `ra`/`rb` the next cycle (bypass); the array update is visible from the next read.
- `stall_req` is combinational from `inst`, `in_valid`, ID/EX state and `stall_in`. There is no path from `wb_*` to `stall_req`.
- Reset mid-stall: the bubble clears; the first valid instruction after reset is loaded on the first non-reset edge.

## Structure
- Package `decode_pkg`:
  - `ctrl_t` packed struct: `rn_src`, `rs_src`, `imm_src`, `imm_ext`, `a1_used`, `a2_used`, `is_load`, `reg_write`, `mem_write`, `branch`, `alu_src`, `flag_write`, `alu_ctrl`[3:0], `cond`[2:0], `mem_to_reg`[1:0].
  - `CTRL_NOP` constant: all zeros.
  - `function decode_ctrl(opcode[9:0])` returning `ctrl_t`.
- Sub-module `regfile_bypass #(N, REG_AW)`:
  - 2 async read ports, 1 sync write port, synchronous reset.
  - PC alias and write-before-read bypass implemented inside it.
- Top contains the address muxes, immediate extend, hazard logic and the ID/EX register.

## Test plan
- **Reset:** assert `rst` 2 cycles with `in_valid`=1 → `out_valid`=0, `ra`=`rb`=`ext_imm`=0, `ctrl_out`=`CTRL_NOP`; afterwards a read of R3 returns 0.
- **Bypass:** R5=0x1234 written via `wb_*` in the same cycle as decoding an instruction reading A1=5 → next cycle `ra`=0x1234; a read of R15 with `pc`=0x40 returns 0x40; `wb_addr`=15 write leaves later R15 reads at `pc`.
- **Immediate:**
  - imm14=0x2000, `imm_ext`=1 → `ext_imm`=0xFFFFE000.
  - Same with `imm_ext`=0 → 0x00002000.
  - imm27=0x4000000, `imm_src`=1, `imm_ext`=1 → 0xFC000000.
- **Load-use:** load to R2, then a consumer with A2=2 → `stall_req`=1 for 1 cycle, one `out_valid`=0 bubble, then the consumer appears; the same consumer with `a2_used`=0 → no stall.
- **Priority:** `stall_in`=1 for 3 cycles → ID/EX unchanged; `flush`+`stall_in` together → `out_valid`=0 next cycle.
- **Reset mid-hazard:** `rst` asserted on the bubble cycle → all outputs 0 the next cycle, no residual `stall_req` once `in_valid`=0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared control definitions for the decode stage.
//   ctrl_t      - packed control bundle carried from ID into EX
//   CTRL_NOP    - all-zero control word used for bubbles and reset
//   decode_ctrl - opcode[9:0] -> ctrl_t control decoder
package decode_pkg;

  typedef struct packed {
    logic       rn_src;
    logic       rs_src;
    logic       imm_src;
    logic       imm_ext;
    logic       a1_used;
    logic       a2_used;
    logic       is_load;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       flag_write;
    logic [3:0] alu_ctrl;
    logic [2:0] cond;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [9:0] OP_ADD  = 10'h004;
  localparam logic [9:0] OP_SUB  = 10'h005;
  localparam logic [9:0] OP_CMP  = 10'h006;
  localparam logic [9:0] OP_ADDI = 10'h008;
  localparam logic [9:0] OP_ORI  = 10'h009;
  localparam logic [9:0] OP_INC  = 10'h00C;
  localparam logic [9:0] OP_LDR  = 10'h010;
  localparam logic [9:0] OP_STR  = 10'h011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd3;

  // Branches own opcode[9:8]=2'b10 and only use opcode[9:5]: the low opcode
  // bits overlap imm27, so they cannot take part in the decode.
  function automatic ctrl_t decode_ctrl(input logic [9:0] opcode);
    ctrl_t c;
    c = CTRL_NOP;
    if (opcode[9:8] == 2'b10) begin
      c.branch  = 1'b1;
      c.imm_src = 1'b1;
      c.imm_ext = 1'b1;
      c.alu_src = 1'b1;
      c.cond    = opcode[7:5];
    end else begin
      case (opcode)
        OP_ADD, OP_SUB: begin
          c.a1_used   = 1'b1;
          c.a2_used   = 1'b1;
          c.reg_write = 1'b1;
          c.alu_ctrl  = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
        end
        OP_CMP: begin
          c.a1_used    = 1'b1;
          c.a2_used    = 1'b1;
          c.flag_write = 1'b1;
          c.alu_ctrl   = ALU_SUB;
        end
        OP_ADDI, OP_ORI: begin
          c.a1_used   = 1'b1;
          c.imm_ext   = (opcode == OP_ADDI);
          c.alu_src   = 1'b1;
          c.reg_write = 1'b1;
          c.alu_ctrl  = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
        end
        OP_INC: begin
          c.rn_src    = 1'b1;
          c.a1_used   = 1'b1;
          c.imm_ext   = 1'b1;
          c.alu_src   = 1'b1;
          c.reg_write = 1'b1;
        end
        OP_LDR: begin
          c.a1_used    = 1'b1;
          c.imm_ext    = 1'b1;
          c.alu_src    = 1'b1;
          c.is_load    = 1'b1;
          c.reg_write  = 1'b1;
          c.mem_to_reg = 2'd1;
        end
        OP_STR: begin
          c.rs_src    = 1'b1;
          c.a1_used   = 1'b1;
          c.a2_used   = 1'b1;
          c.imm_ext   = 1'b1;
          c.alu_src   = 1'b1;
          c.mem_write = 1'b1;
        end
        default: c = CTRL_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/decode_pipe_stage_regfile.sv
// regfile_bypass: 2 async read ports, 1 sync write port, sync active-high reset.
//   ra1/ra2 -> rd1/rd2 : read ports; the all-ones address returns pc
//   we/wa/wd           : write port; writes to the all-ones address are dropped
// A same-cycle write to a read address is forwarded to the read port.
module regfile_bypass
  import decode_pkg::*;
#(
  parameter int N      = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [N-1:0]      rd1,
  output logic [N-1:0]      rd2,
  input  logic [N-1:0]      pc,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [N-1:0]      wd
);

  localparam logic [REG_AW-1:0] PC_ALIAS = '1;

  logic [N-1:0] rf_mem [2**REG_AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_AW; i++) rf_mem[i] <= '0;
    end else if (we && (wa != PC_ALIAS)) begin
      rf_mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == PC_ALIAS)      ? pc :
               (we && (wa == ra1))    ? wd : rf_mem[ra1];
  assign rd2 = (ra2 == PC_ALIAS)      ? pc :
               (we && (wa == ra2))    ? wd : rf_mem[ra2];

endmodule

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: instruction decode with integrated ID/EX register.
//   in_valid/inst/pc      : fetched instruction (held by fetch while stall_req)
//   stall_in / flush      : downstream hold / kill of the entering instruction
//   wb_we/wb_addr/wb_data : writeback port into the register file
//   out_valid, ra, rb, ext_imm, rd_out, ra_addr, rb_addr, ctrl_out : ID/EX bundle
//   stall_req             : combinational fetch hold (load-use hazard or stall_in)
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int N      = 32,
  parameter int REG_AW = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [N-1:0]             inst,
  input  logic [N-1:0]             pc,
  input  logic                     stall_in,
  input  logic                     flush,
  input  logic                     wb_we,
  input  logic [REG_AW-1:0]        wb_addr,
  input  logic [N-1:0]             wb_data,
  output logic                     out_valid,
  output logic [N-1:0]             ra,
  output logic [N-1:0]             rb,
  output logic [N-1:0]             ext_imm,
  output logic [REG_AW-1:0]        rd_out,
  output logic [REG_AW-1:0]        ra_addr,
  output logic [REG_AW-1:0]        rb_addr,
  output logic [$bits(ctrl_t)-1:0] ctrl_out,
  output logic                     stall_req
);

  localparam logic [REG_AW-1:0] PC_ALIAS = '1;

  // Sign extension starts from the MSB of the field actually selected
  // (bit 13 for imm14, bit 26 for imm27), not from the padded 27-bit value.
  function automatic logic [N-1:0] extend_imm(input logic [31:0] iw,
                                               input logic imm_src,
                                               input logic imm_ext);
    logic [N-1:0] v;
    if (imm_src) v = {{(N-27){imm_ext & iw[26]}}, iw[26:0]};
    else         v = {{(N-14){imm_ext & iw[13]}}, iw[13:0]};
    return v;
  endfunction

  // ---- stage p0: decode, operand read, immediate, hazard ----
  ctrl_t              ctrl_p0;
  logic [REG_AW-1:0]  a1_p0, a2_p0, rd_p0;
  logic [N-1:0]       ra_p0, rb_p0, imm_p0;
  logic               hazard_p0;

  ctrl_t              ctrl_p1;
  logic               vld_p1;
  logic [N-1:0]       ra_p1, rb_p1, imm_p1;
  logic [REG_AW-1:0]  rd_p1, a1_p1, a2_p1;

  assign ctrl_p0 = decode_ctrl(inst[31:22]);
  assign a1_p0   = ctrl_p0.rn_src ? inst[17:14] : inst[21:18];
  assign a2_p0   = ctrl_p0.rs_src ? inst[17:14] : inst[13:10];
  assign rd_p0   = inst[17:14];
  assign imm_p0  = extend_imm(inst[31:0], ctrl_p0.imm_src, ctrl_p0.imm_ext);

  regfile_bypass #(.N(N), .REG_AW(REG_AW)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (a1_p0),
    .ra2 (a2_p0),
    .rd1 (ra_p0),
    .rd2 (rb_p0),
    .pc  (pc),
    .we  (wb_we),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  assign hazard_p0 = in_valid && vld_p1 && ctrl_p1.is_load && (rd_p1 != PC_ALIAS) &&
                     ((ctrl_p0.a1_used && (a1_p0 == rd_p1)) ||
                      (ctrl_p0.a2_used && (a2_p0 == rd_p1)));
  assign stall_req = hazard_p0 || stall_in;

  // ---- stage p1: ID/EX register ----
  // Reset, flush and a hazard bubble all clear the bundle; flush wins over stall_in.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall_in && hazard_p0)) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= CTRL_NOP;
      ra_p1   <= '0;
      rb_p1   <= '0;
      imm_p1  <= '0;
      rd_p1   <= '0;
      a1_p1   <= '0;
      a2_p1   <= '0;
    end else if (!stall_in) begin
      vld_p1  <= in_valid;
      ctrl_p1 <= in_valid ? ctrl_p0 : CTRL_NOP;
      ra_p1   <= ra_p0;
      rb_p1   <= rb_p0;
      imm_p1  <= imm_p0;
      rd_p1   <= rd_p0;
      a1_p1   <= a1_p0;
      a2_p1   <= a2_p0;
    end
  end

  assign out_valid = vld_p1;
  assign ra        = ra_p1;
  assign rb        = rb_p1;
  assign ext_imm   = imm_p1;
  assign rd_out    = rd_p1;
  assign ra_addr   = a1_p1;
  assign rb_addr   = a2_p1;
  assign ctrl_out  = ctrl_p1;

endmodule

// File: tb/tb_decode_pipe_stage.sv
module tb_decode_pipe_stage;
  import decode_pkg::*;

  typedef struct packed {
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] imm;
    logic [3:0]  rd;
    logic [3:0]  a1;
    logic [3:0]  a2;
    ctrl_t       ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall_in, flush, wb_we;
  logic [31:0] inst, pc, wb_data;
  logic [3:0]  wb_addr;
  logic        out_valid, stall_req;
  logic [31:0] ra, rb, ext_imm;
  logic [3:0]  rd_out, ra_addr, rb_addr;
  ctrl_t       ctrl_out;
  exp_t        obs;

  int checks   = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [31:0] rf_m [16];

  always #5 clk = ~clk;

  decode_pipe_stage #(.N(32), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .pc(pc),
    .stall_in(stall_in), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .ra(ra), .rb(rb),
    .ext_imm(ext_imm), .rd_out(rd_out), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ctrl_out(ctrl_out), .stall_req(stall_req)
  );

  assign obs = {ra, rb, ext_imm, rd_out, ra_addr, rb_addr, ctrl_out};

  // Reference control table for the opcodes this bench uses.
  function automatic ctrl_t ref_ctrl(input logic [9:0] op);
    ctrl_t c;
    c = '0;
    if (op[9:5] == 5'b10000) begin
      c.branch = 1; c.imm_src = 1; c.imm_ext = 1; c.alu_src = 1;
    end else begin
      case (op)
        10'h004: begin c.a1_used = 1; c.a2_used = 1; c.reg_write = 1; end
        10'h008: begin c.a1_used = 1; c.imm_ext = 1; c.alu_src = 1; c.reg_write = 1; end
        10'h009: begin c.a1_used = 1; c.alu_src = 1; c.reg_write = 1; c.alu_ctrl = 4'd3; end
        10'h010: begin
          c.a1_used = 1; c.imm_ext = 1; c.alu_src = 1; c.is_load = 1;
          c.reg_write = 1; c.mem_to_reg = 2'd1;
        end
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  function automatic logic [31:0] ref_read(input logic [3:0] a, input logic [31:0] p);
    if (a == 4'hF) return p;
    if (wb_we && wb_addr == a) return wb_data;
    return rf_m[a];
  endfunction

  function automatic exp_t exp_for(input logic [31:0] i, input logic [31:0] p);
    exp_t  e;
    ctrl_t c;
    c      = ref_ctrl(i[31:22]);
    e.ctrl = c;
    e.a1   = c.rn_src ? i[17:14] : i[21:18];
    e.a2   = c.rs_src ? i[17:14] : i[13:10];
    e.rd   = i[17:14];
    e.ra   = ref_read(e.a1, p);
    e.rb   = ref_read(e.a2, p);
    if (c.imm_src) e.imm = c.imm_ext ? {{5{i[26]}}, i[26:0]} : {5'b0, i[26:0]};
    else           e.imm = c.imm_ext ? {{18{i[13]}}, i[13:0]} : {18'b0, i[13:0]};
    return e;
  endfunction

  function automatic logic [31:0] mk_r(input logic [9:0] op, input logic [3:0] a1,
                                       input logic [3:0] rd, input logic [3:0] a2);
    return {op, a1, rd, a2, 10'h000};
  endfunction

  function automatic logic [31:0] mk_i(input logic [9:0] op, input logic [3:0] a1,
                                       input logic [3:0] rd, input logic [13:0] imm);
    return {op, a1, rd, imm};
  endfunction

  task automatic issue(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    inst     = i;
    pc       = p;
    sb.push_back(exp_for(i, p));
  endtask

  task automatic tick();
    logic        we, r;
    logic [3:0]  a;
    logic [31:0] d;
    we = wb_we; a = wb_addr; d = wb_data; r = rst;
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < 16; k++) rf_m[k] = '0;
    end else if (we && a != 4'hF) begin
      rf_m[a] = d;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    in_valid = 1'b1;
    inst = mk_r(10'h004, 4'd3, 4'd1, 4'd3);
    pc = 32'h0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_valid: got %b want 0", out_valid);
    end
    checks++;
    if (obs !== '0) begin
      failures++; $display("FAIL rst_bundle: got %h want 0", obs);
    end
    rst = 1'b0;
    issue(mk_r(10'h004, 4'd3, 4'd1, 4'd3), 32'h0);
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      failures++; $display("FAIL rst_read_r3: got vld=%b %h want %h", out_valid, obs, e);
    end
    checks++;
    if (ra !== 32'h0) begin
      failures++; $display("FAIL rst_r3_zero: got %h want 0", ra);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    wb_we = 1'b1; wb_addr = 4'd5; wb_data = 32'h1234;
    issue(mk_r(10'h004, 4'd5, 4'd7, 4'd0), 32'h20);
    tick();
    wb_we = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      failures++; $display("FAIL byp_same_cycle: got vld=%b %h want %h", out_valid, obs, e);
    end
    checks++;
    if (ra !== 32'h1234) begin
      failures++; $display("FAIL byp_ra: got %h want 00001234", ra);
    end
    issue(mk_r(10'h004, 4'd15, 4'd7, 4'd5), 32'h40);
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e || ra !== 32'h40 || rb !== 32'h1234) begin
      failures++; $display("FAIL byp_pc_alias: got ra=%h rb=%h want 00000040 00001234", ra, rb);
    end
    wb_we = 1'b1; wb_addr = 4'd15; wb_data = 32'hDEAD;
    issue(mk_r(10'h004, 4'd15, 4'd7, 4'd15), 32'h40);
    tick();
    wb_we = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e || ra !== 32'h40) begin
      failures++; $display("FAIL byp_alias_wr: got ra=%h want 00000040", ra);
    end
    issue(mk_r(10'h004, 4'd15, 4'd7, 4'd15), 32'h80);
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e || rb !== 32'h80) begin
      failures++; $display("FAIL byp_alias_kept: got rb=%h want 00000080", rb);
    end
  endtask

  task automatic test_imm();
    exp_t e;
    issue(mk_i(10'h008, 4'd5, 4'd2, 14'h2000), 32'h50);
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e || ext_imm !== 32'hFFFFE000) begin
      failures++; $display("FAIL imm14_sext: got %h want FFFFE000", ext_imm);
    end
    issue(mk_i(10'h009, 4'd5, 4'd2, 14'h2000), 32'h54);
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e || ext_imm !== 32'h00002000) begin
      failures++; $display("FAIL imm14_zext: got %h want 00002000", ext_imm);
    end
    issue(32'h84000000, 32'h58);
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e || ext_imm !== 32'hFC000000) begin
      failures++; $display("FAIL imm27_sext: got %h ctrl=%h want FC000000", ext_imm, ctrl_out);
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    issue(mk_i(10'h010, 4'd1, 4'd2, 14'd4), 32'h10);
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      failures++; $display("FAIL lu_load: got vld=%b %h want %h", out_valid, obs, e);
    end
    in_valid = 1'b1;
    inst = mk_r(10'h004, 4'd3, 4'd4, 4'd2);
    pc = 32'h14;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      failures++; $display("FAIL lu_stall: got %b want 1", stall_req);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || ctrl_out !== '0) begin
      failures++; $display("FAIL lu_bubble: got vld=%b ctrl=%h want 0 0", out_valid, ctrl_out);
    end
    checks++;
    if (stall_req !== 1'b0) begin
      failures++; $display("FAIL lu_release: got %b want 0", stall_req);
    end
    issue(mk_r(10'h004, 4'd3, 4'd4, 4'd2), 32'h14);
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      failures++; $display("FAIL lu_consumer: got vld=%b %h want %h", out_valid, obs, e);
    end
    issue(mk_i(10'h010, 4'd1, 4'd2, 14'd8), 32'h18);
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      failures++; $display("FAIL lu_load2: got vld=%b %h want %h", out_valid, obs, e);
    end
    issue(mk_i(10'h008, 4'd3, 4'd4, 14'h0800), 32'h1C);
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      failures++; $display("FAIL lu_no_stall: got %b want 0", stall_req);
    end
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      failures++; $display("FAIL lu_a2_unused: got vld=%b %h want %h", out_valid, obs, e);
    end
  endtask

  task automatic test_priority();
    exp_t e, hold;
    issue(mk_r(10'h004, 4'd5, 4'd6, 4'd2), 32'h60);
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      failures++; $display("FAIL pri_load: got vld=%b %h want %h", out_valid, obs, e);
    end
    hold = e;
    stall_in = 1'b1;
    inst = mk_r(10'h004, 4'd1, 4'd1, 4'd1);
    pc = 32'h64;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      failures++; $display("FAIL pri_stall_req: got %b want 1", stall_req);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || obs !== hold) begin
        failures++; $display("FAIL pri_hold%0d: got vld=%b %h want %h", k, out_valid, obs, hold);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || obs !== '0) begin
      failures++; $display("FAIL pri_flush_stall: got vld=%b %h want 0", out_valid, obs);
    end
    flush = 1'b0;
    stall_in = 1'b0;
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || ctrl_out !== '0) begin
      failures++; $display("FAIL pri_idle: got vld=%b ctrl=%h want 0 0", out_valid, ctrl_out);
    end
  endtask

  task automatic test_reset_mid_hazard();
    exp_t e;
    wb_we = 1'b1; wb_addr = 4'd3; wb_data = 32'h55;
    issue(mk_i(10'h010, 4'd1, 4'd2, 14'd4), 32'h70);
    tick();
    wb_we = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      failures++; $display("FAIL rh_load: got vld=%b %h want %h", out_valid, obs, e);
    end
    in_valid = 1'b1;
    inst = mk_r(10'h004, 4'd3, 4'd4, 4'd2);
    pc = 32'h74;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      failures++; $display("FAIL rh_stall: got %b want 1", stall_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || obs !== '0) begin
      failures++; $display("FAIL rh_reset: got vld=%b %h want 0", out_valid, obs);
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      failures++; $display("FAIL rh_no_stall: got %b want 0", stall_req);
    end
    issue(mk_r(10'h004, 4'd3, 4'd4, 4'd2), 32'h74);
    tick();
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e || ra !== 32'h0) begin
      failures++; $display("FAIL rh_first_valid: got vld=%b ra=%h want 1 0", out_valid, ra);
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) rf_m[k] = '0;
    rst = 1'b1; in_valid = 1'b0; inst = '0; pc = '0;
    stall_in = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    test_reset();
    test_bypass();
    test_imm();
    test_load_use();
    test_priority();
    test_reset_mid_hazard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
